// File: rtl/idct8x8_2d.sv
// 8x8 2-D inverse DCT: row pass into a transpose buffer, then column pass into the
// output buffer, both through one shared 8-tap multiply-accumulate (one element per cycle).
module idct8x8_2d #(
  parameter int IN_W    = 32,
  parameter int FRAC    = 15,
  parameter int CONST_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64*IN_W-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [64*IN_W-1:0]   out_data
);

  localparam int AccW = IN_W + CONST_W + 3;
  localparam logic signed [AccW-1:0] Half = AccW'(1) <<< (FRAC - 1);

  typedef enum logic [1:0] {StIdle, StRow, StCol, StDone} state_e;

  state_e            state_q;
  logic [5:0]        cnt_q;
  logic              in_ready_q;
  logic              out_valid_q;

  logic signed [IN_W-1:0]    coef_q    [64];
  logic signed [IN_W-1:0]    trans_q   [64];
  logic signed [IN_W-1:0]    out_buf_q [64];

  logic signed [IN_W-1:0]    tap [8];
  logic signed [CONST_W-1:0] cst [8];
  logic signed [AccW-1:0]    acc;
  logic signed [AccW-1:0]    rnd;
  logic signed [AccW-1:0]    shf;
  logic signed [IN_W-1:0]    mac_res;

  // C[n][k] = round(c(k) * cos((2n+1)k*pi/16) * 2^15); the angle is folded onto 0..pi/2
  function automatic logic signed [CONST_W-1:0] cos_const(input logic [2:0] n,
                                                          input logic [2:0] k);
    int   j;
    int   mag;
    logic neg;
    if (k == 3'd0) begin
      return CONST_W'(11585);
    end
    j = ((int'(n) * 2 + 1) * int'(k)) % 32;
    if (j > 16) j = 32 - j;
    neg = (j > 8);
    if (neg) j = 16 - j;
    case (j)
      0:       mag = 16384;
      1:       mag = 16069;
      2:       mag = 15137;
      3:       mag = 13623;
      4:       mag = 11585;
      5:       mag = 9102;
      6:       mag = 6270;
      7:       mag = 3196;
      default: mag = 0;
    endcase
    return neg ? CONST_W'(-mag) : CONST_W'(mag);
  endfunction

  // Row pass reads row cnt[5:3] of X; column pass reads column cnt[5:3] of trans.
  // In both passes the output index is cnt[2:0].
  always_comb begin
    acc = '0;
    for (int k = 0; k < 8; k++) begin
      if (state_q == StCol) begin
        tap[k] = trans_q[{3'(k), cnt_q[5:3]}];
      end else begin
        tap[k] = coef_q[{cnt_q[5:3], 3'(k)}];
      end
      cst[k] = cos_const(cnt_q[2:0], 3'(k));
      acc    = acc + AccW'(tap[k]) * AccW'(cst[k]);
    end
    rnd = acc + Half;
    shf = rnd >>> FRAC;
    if (shf[AccW-1:IN_W-1] == '0 || shf[AccW-1:IN_W-1] == '1) begin
      mac_res = shf[IN_W-1:0];
    end else if (shf[AccW-1]) begin
      mac_res = {1'b1, {(IN_W-1){1'b0}}};
    end else begin
      mac_res = {1'b0, {(IN_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      for (int i = 0; i < 64; i++) begin
        out_buf_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            state_q    <= StRow;
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
          end
        end
        StRow: begin
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_q <= StCol;
        end
        StCol: begin
          out_buf_q[{cnt_q[2:0], cnt_q[5:3]}] <= mac_res;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd63) state_q <= StDone;
        end
        StDone: begin
          // out_valid is raised one cycle into DONE and must be seen before release
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == StIdle && in_valid) begin
      for (int i = 0; i < 64; i++) begin
        coef_q[i] <= in_data[i*IN_W +: IN_W];
      end
    end
    if (state_q == StRow) begin
      trans_q[cnt_q] <= mac_res;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;

  always_comb begin
    out_data = '0;
    for (int i = 0; i < 64; i++) begin
      out_data[i*IN_W +: IN_W] = out_buf_q[i];
    end
  end

endmodule

// File: doc/idct8x8_2d.md
Name: idct8x8_2d

Overview:
- 8×8 2-D inverse DCT; the decode-side counterpart of the forward 8×8 DCT block.
- Takes a flattened 64-coefficient block and returns a flattened 64-sample spatial block.
- Row-column decomposition through an internal 64-entry transpose buffer, using one shared 8-tap multiply-accumulate that computes one 1-D output element per cycle.
- Self-contained: cosine constants come from an internal ROM; no 1-D core is instantiated.

Parameters:
IN_W, 32, signed width of every coefficient, intermediate and output sample
FRAC, 15, fractional bits of the cosine constants
CONST_W, 16, signed width of each cosine constant

Ports:
clk  input  1  clock; all logic on the rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  coefficient block valid
in_ready  output  1  block accepted on the edge where in_valid && in_ready
in_data  input  64*IN_W  signed X[u][v] at bits [(u*8+v)*IN_W +: IN_W]
out_valid  output  1  spatial block available
out_ready  input  1  consumer accepts the block
out_data  output  64*IN_W  signed x[m][n] at bits [(m*8+n)*IN_W +: IN_W]

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Constants: C[n][k] = round(c(k)·cos((2n+1)kπ/16)·2^FRAC), with c(0)=sqrt(1/8) and c(k>0)=1/2. Stored signed at CONST_W bits. Examples: C[n][0]=11585, C[0][1]=16069.
- 1-D element: acc = Σk C[n][k]·a[k], accumulated at IN_W+CONST_W+3 bits.
  - Result = (acc + 2^(FRAC-1)) >>> FRAC, an arithmetic shift.
  - The result saturates to the signed IN_W range. This applies in both passes.
- States: IDLE, ROW, COL, DONE. A 6-bit counter cnt runs in ROW and COL.
- IDLE:
  - in_ready=1.
  - On in_valid, in_data is captured into the coefficient buffer, cnt←0, and the state moves to ROW.
- ROW (64 cycles):
  - u=cnt[5:3], n=cnt[2:0].
  - Computes T[u][n] = 1-D(row u of X, output n) and writes trans[u*8+n] at the clock edge.
  - At cnt==63: cnt←0 and the state moves to COL.
- COL (64 cycles):
  - n=cnt[5:3], m=cnt[2:0].
  - Computes x[m][n] from column n of trans and writes out_buf[m*8+n].
  - At cnt==63 the state moves to DONE.
- DONE:
  - out_valid=1, and out_data is held stable.
  - On out_ready, the state moves to IDLE.
- Latency: out_valid rises exactly 129 rising edges after the accepting edge. in_ready rises one cycle after the out_ready handshake. Peak throughput is one block per 131 cycles.
- in_ready=0 outside IDLE. in_valid and in_data are ignored there.
- out_valid=0 outside DONE. out_data keeps the last completed block until the next COL pass overwrites it.
- Reset values, including reset mid-block:
  - state=IDLE, cnt=0, out_valid=0, in_ready=1, out_buf cleared (out_data=0).
  - The partial block is discarded.
  - trans and the coefficient buffer need no reset.
- out_ready while not in DONE has no effect.
- in_valid in the same cycle as rst is ignored.

Test Plan:
- All-zero input block → out_data all 0 after 129 cycles; in_ready low from accept until one cycle after the out_ready handshake.
- DC-only input X[0][0]=64, rest 0 → all 64 outputs = 8 (intermediate T[0][n]=23).
- X[0][1]=100, rest 0 → column 0 outputs all 17, column 7 all −17, and the pattern is identical in every row.
- IN_W=16, all X[u][v]=32767 → intermediates and outputs saturate; no output wraps negative, and x[0][0]=32767.
- out_ready held low for 20 cycles in DONE → out_valid and out_data stable, a new in_valid is ignored, and in_ready stays 0. Then release out_ready → IDLE and the next block is processed correctly.
- Assert rst at cnt=30 of COL → out_valid=0 and out_data=0 immediately. A block sent after reset gives correct results, and a back-to-back stream of 3 random blocks matches the floating-point IDCT within ±1 LSB per sample.
